// File: rtl/ascon_pack.sv
// Shared ASCON types: the 5x64 state, the reader FSM encoding and lane helpers.
package ascon_pack;

  localparam int NB_STATE_WORDS = 5;
  localparam int WORD_W         = 64;

  // Lane k of the state is type_state[k] (x0 .. x4).
  typedef logic [NB_STATE_WORDS-1:0][WORD_W-1:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } type_reader_fsm;

  // Advance a lane index with wrap from x4 back to x0.
  function automatic logic [2:0] next_lane(input logic [2:0] idx);
    return (idx == 3'd4) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/ascon_state_reader.sv
// Snapshots the ASCON state on start and streams selected 64-bit lanes
// over a valid/ready interface, wrapping from x4 to x0.
module ascon_state_reader
  import ascon_pack::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  type_state   state_i,
  input  logic        start_i,
  input  logic [2:0]  first_word_i,
  input  logic [2:0]  nb_words_i,
  input  logic        ready_i,
  output logic [63:0] word_o,
  output logic        valid_o,
  output logic        last_o,
  output logic        busy_o,
  output logic        done_o
);

  // Handshake: a lane transfers at a rising edge where valid_o=1 and ready_i=1.
  // Once valid_o rises it stays high, with word_o/last_o stable, until that
  // transfer happens; word_o reads as zero whenever valid_o is low.

  type_reader_fsm state_q, state_d;
  type_state      snapshot_q, snapshot_d;
  logic [2:0]     index_q, index_d;
  logic [2:0]     remaining_q, remaining_d;

  logic [2:0]     first_clean;
  logic [2:0]     count_clean;
  logic [63:0]    lane_sel;

  // Out-of-range config is folded into the legal range at capture time.
  always_comb begin
    first_clean = (first_word_i >= 3'd5) ? 3'd0 : first_word_i;
    count_clean = (nb_words_i > 3'd5) ? 3'd5 : nb_words_i;
  end

  // State, snapshot and counters; all return to zero on reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      snapshot_q  <= '0;
      index_q     <= 3'd0;
      remaining_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      snapshot_q  <= snapshot_d;
      index_q     <= index_d;
      remaining_q <= remaining_d;
    end
  end

  // Next state: capture only in IDLE, step through lanes on each transfer.
  always_comb begin
    state_d     = state_q;
    snapshot_d  = snapshot_q;
    index_d     = index_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          snapshot_d  = state_i;
          index_d     = first_clean;
          remaining_d = count_clean;
          state_d     = (count_clean == 3'd0) ? DONE : SEND;
        end
      end
      SEND: begin
        // valid_o is high throughout SEND, so ready_i alone marks a transfer.
        if (ready_i) begin
          if (remaining_q == 3'd1) begin
            remaining_d = 3'd0;
            state_d     = DONE;
          end else begin
            index_d     = next_lane(index_q);
            remaining_d = remaining_q - 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane multiplexer over the frozen snapshot.
  always_comb begin
    lane_sel = 64'd0;
    case (index_q)
      3'd0:    lane_sel = snapshot_q[0];
      3'd1:    lane_sel = snapshot_q[1];
      3'd2:    lane_sel = snapshot_q[2];
      3'd3:    lane_sel = snapshot_q[3];
      3'd4:    lane_sel = snapshot_q[4];
      default: lane_sel = 64'd0;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    valid_o = (state_q == SEND);
    word_o  = valid_o ? lane_sel : 64'd0;
    last_o  = valid_o && (remaining_q == 3'd1);
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
  end

endmodule

// File: tb/tb_ascon_state_reader.sv
// Directed bench for ascon_state_reader: full dump, wrap with backpressure,
// snapshot freeze, zero/clamped config and reset mid-readout.
module tb_ascon_state_reader;
  import ascon_pack::*;

  logic        clk;
  logic        rst;
  type_state   state_in;
  logic        start;
  logic [2:0]  first_word;
  logic [2:0]  nb_words;
  logic        ready;
  logic [63:0] word;
  logic        valid;
  logic        last;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  int transfers;
  int done_count;

  ascon_state_reader dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .state_i      (state_in),
    .start_i      (start),
    .first_word_i (first_word),
    .nb_words_i   (nb_words),
    .ready_i      (ready),
    .word_o       (word),
    .valid_o      (valid),
    .last_o       (last),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] lane_val(input int k);
    logic [63:0] base;
    base = 64'hA5A5_0000_0000_0000;
    return base | 64'(k);
  endfunction

  task automatic set_pattern_state();
    for (int k = 0; k < 5; k++) state_in[k] = lane_val(k);
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_word"},  word,  64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_last"},  64'(last),  64'd0);
    check({tag, "_busy"},  64'(busy),  64'd0);
    check({tag, "_done"},  64'(done),  64'd0);
  endtask

  // Start a readout and check every lane with ready held high, then DONE/IDLE.
  task automatic run_stream(input string tag, input logic [2:0] f, input logic [2:0] n,
                            input int exp_first, input int exp_count);
    first_word = f;
    nb_words   = n;
    ready      = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < exp_count; k++) begin
      check({tag, "_word"},  word, lane_val((exp_first + k) % 5));
      check({tag, "_valid"}, 64'(valid), 64'd1);
      check({tag, "_last"},  64'(last), 64'(k == exp_count - 1));
      check({tag, "_busy"},  64'(busy), 64'd1);
      tick();
    end
    check({tag, "_done"},      64'(done),  64'd1);
    check({tag, "_done_busy"}, 64'(busy),  64'd1);
    check({tag, "_done_valid"},64'(valid), 64'd0);
    tick();
    check({tag, "_end_busy"},  64'(busy),  64'd0);
    check({tag, "_end_done"},  64'(done),  64'd0);
  endtask

  logic [63:0] exp_words [5];
  logic        exp_last  [5];
  logic        ready_pat [5];

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    first_word = 3'd0;
    nb_words   = 3'd0;
    ready      = 1'b0;
    set_pattern_state();

    // Reset state.
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Full dump x0..x4.
    run_stream("full", 3'd0, 3'd5, 0, 5);

    // Wrap with backpressure: x3, x4 (held twice), x4, x0.
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_words = '{lane_val(3), lane_val(4), lane_val(4), lane_val(4), lane_val(0)};
    exp_last  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    transfers = 0;
    first_word = 3'd3;
    nb_words   = 3'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      ready = ready_pat[c];
      check("wrap_word",  word, exp_words[c]);
      check("wrap_valid", 64'(valid), 64'd1);
      check("wrap_last",  64'(last),  64'(exp_last[c]));
      if (valid && ready) transfers++;
      tick();
    end
    check("wrap_transfers", 64'(transfers), 64'd3);
    check("wrap_done",  64'(done),  64'd1);
    check("wrap_valid_after", 64'(valid), 64'd0);
    tick();
    check("wrap_end_busy", 64'(busy), 64'd0);
    ready = 1'b1;

    // Snapshot freeze and ignored start during SEND and DONE.
    done_count = 0;
    first_word = 3'd0;
    nb_words   = 3'd5;
    start      = 1'b1;
    tick();
    state_in   = '1;
    first_word = 3'd2;
    nb_words   = 3'd1;
    for (int k = 0; k < 5; k++) begin
      check("snap_word", word, lane_val(k));
      check("snap_last", 64'(last), 64'(k == 4));
      tick();
    end
    // start still high in DONE: must be ignored.
    if (done) done_count++;
    check("snap_done", 64'(done), 64'd1);
    tick();
    start = 1'b0;
    check("snap_idle_busy", 64'(busy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      if (done) done_count++;
      check("snap_no_second", 64'(valid), 64'd0);
      tick();
    end
    check("snap_done_once", 64'(done_count), 64'd1);
    set_pattern_state();

    // Zero count: straight to DONE, no valid.
    first_word = 3'd1;
    nb_words   = 3'd0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("zero_valid", 64'(valid), 64'd0);
    check("zero_done",  64'(done),  64'd1);
    check("zero_busy",  64'(busy),  64'd1);
    tick();
    check("zero_valid2", 64'(valid), 64'd0);
    check("zero_end_busy", 64'(busy), 64'd0);
    check("zero_end_done", 64'(done), 64'd0);

    // Clamp: first=6, nb=7 behaves as first=0, nb=5.
    run_stream("clamp", 3'd6, 3'd7, 0, 5);

    // Reset after the second transfer aborts the readout.
    first_word = 3'd0;
    nb_words   = 3'd5;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("abort_w0", word, lane_val(0));
    tick();
    check("abort_w1", word, lane_val(1));
    tick();
    check("abort_w2", word, lane_val(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("abort");
    tick();
    check("abort_no_done", 64'(done), 64'd0);
    check("abort_no_busy", 64'(busy), 64'd0);

    // Single lane x4 after the abort.
    run_stream("single", 3'd4, 3'd1, 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
